// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the ALU arbiter slice.
//   - ALU opcode encodings (3-bit)
//   - FSM state encoding for the arbiter/sequencer
//   - helpers classifying opcodes for response masking
package alu_arbiter_pkg;

  localparam int unsigned ALU_WIDTH = 32;
  localparam int unsigned ALU_OPW   = 3;

  localparam logic [2:0] OP_AND     = 3'b000;
  localparam logic [2:0] OP_OR      = 3'b001;
  localparam logic [2:0] OP_ADD     = 3'b010;
  localparam logic [2:0] OP_BNE     = 3'b011;
  localparam logic [2:0] OP_ILLEGAL = 3'b100;
  localparam logic [2:0] OP_BEQ     = 3'b101;
  localparam logic [2:0] OP_SUB     = 3'b110;
  localparam logic [2:0] OP_SLT     = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_e;

  function automatic logic is_branch(input logic [2:0] op);
    return (op == OP_BNE) || (op == OP_BEQ);
  endfunction

  function automatic logic is_illegal(input logic [2:0] op);
    return op == OP_ILLEGAL;
  endfunction

endpackage

// File: rtl/alu_arbiter_rr_arb2.sv
// rr_arb2: two-input round-robin grant.
//   clk, rst    : clock, async active-high reset
//   req[1:0]    : request vector (bit N = requester N)
//   update      : strobe that commits update_id as the last winner
//   update_id   : id of the requester just completed
//   grant[1:0]  : one-hot (or zero) combinational grant
// On a tie the requester that did not win last is granted; a lone
// requester always wins. last_grant resets to 1 so requester 0 wins
// the first tie.
module rr_arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       update,
  input  logic       update_id,
  output logic [1:0] grant
);

  logic last_grant_q;
  logic last_grant_d;

  always_comb begin
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_grant_q ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

  always_comb begin
    last_grant_d = last_grant_q;
    if (update) begin
      last_grant_d = update_id;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant_q <= 1'b1;
    end else begin
      last_grant_q <= last_grant_d;
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one combinational ALU between two requesters.
//   req0_* / req1_* : valid/ready request channels (a, b, op)
//   alu_data1/2, alu_op : registered operands/opcode to the ALU
//   alu_result, alu_zero, alu_branch : combinational ALU outputs
//   rsp_*           : valid/ready response channel (id, result, flags)
//
// Handshake semantics (both channels): a transfer happens in a cycle
// where valid and ready are both high at the rising clock edge. A source
// holds valid and its payload stable until it sees ready; it may drop
// valid before that, in which case nothing transfers. reqN_ready is only
// ever high in IDLE; rsp_valid is high exactly while in RESP.
//
// Sequence: IDLE (grant + capture) -> ISSUE (ALU evaluates) -> RESP
// (wait for rsp_ready). The arbiter's history advances at the response
// handshake, so an operation discarded by reset leaves it untouched.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int OPW   = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0_valid,
  input  logic             req1_valid,
  output logic             req0_ready,
  output logic             req1_ready,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  input  logic [OPW-1:0]   req0_op,
  input  logic [OPW-1:0]   req1_op,
  output logic [WIDTH-1:0] alu_data1,
  output logic [WIDTH-1:0] alu_data2,
  output logic [OPW-1:0]   alu_op,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zero,
  input  logic             alu_branch,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic             rsp_id,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_zero,
  output logic             rsp_branch,
  output logic             rsp_err
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [OPW-1:0]   op_q, op_d;
  logic             id_q, id_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             zero_q, zero_d;
  logic             branch_q, branch_d;
  logic             err_q, err_d;

  logic [1:0]       arb_req;
  logic [1:0]       grant;
  logic             rsp_fire;

  // Requests are only presented to the arbiter in IDLE, so a grant (and
  // therefore reqN_ready) can never appear in ISSUE or RESP.
  assign arb_req  = (state_q == ST_IDLE) ? {req1_valid, req0_valid} : 2'b00;
  assign rsp_fire = (state_q == ST_RESP) && rsp_ready;

  rr_arb2 u_rr_arb2 (
    .clk       (clk),
    .rst       (rst),
    .req       (arb_req),
    .update    (rsp_fire),
    .update_id (id_q),
    .grant     (grant)
  );

  assign req0_ready = grant[0];
  assign req1_ready = grant[1];

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    id_d     = id_q;
    res_d    = res_q;
    zero_d   = zero_q;
    branch_d = branch_q;
    err_d    = err_q;

    case (state_q)
      ST_IDLE: begin
        if (grant != 2'b00) begin
          id_d    = grant[1];
          a_d     = grant[1] ? req1_a  : req0_a;
          b_d     = grant[1] ? req1_b  : req0_b;
          op_d    = grant[1] ? req1_op : req0_op;
          state_d = ST_ISSUE;
        end
      end

      ST_ISSUE: begin
        // Illegal opcode is checked first: the ALU output is not trusted.
        if (is_illegal(op_q)) begin
          res_d    = '0;
          zero_d   = 1'b0;
          branch_d = 1'b0;
          err_d    = 1'b1;
        end else if (is_branch(op_q)) begin
          res_d    = '0;
          zero_d   = 1'b0;
          branch_d = alu_branch;
          err_d    = 1'b0;
        end else begin
          res_d    = alu_result;
          zero_d   = alu_zero;
          branch_d = 1'b0;
          err_d    = 1'b0;
        end
        state_d = ST_RESP;
      end

      ST_RESP: begin
        if (rsp_ready) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      id_q     <= 1'b0;
      res_q    <= '0;
      zero_q   <= 1'b0;
      branch_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      id_q     <= id_d;
      res_q    <= res_d;
      zero_q   <= zero_d;
      branch_q <= branch_d;
      err_q    <= err_d;
    end
  end

  // ALU ports come straight from the issue registers; they only change
  // when a new operation is captured.
  assign alu_data1  = a_q;
  assign alu_data2  = b_q;
  assign alu_op     = op_q;

  assign rsp_valid  = (state_q == ST_RESP);
  assign rsp_id     = id_q;
  assign rsp_result = res_q;
  assign rsp_zero   = zero_q;
  assign rsp_branch = branch_q;
  assign rsp_err    = err_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed testbench for alu_arbiter. A small behavioural ALU sits beside
// the DUT; on branch and illegal opcodes it drives deliberately
// misleading result/flag values so response masking is visible.
module tb_alu_arbiter;

  logic        clk;
  logic        rst;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [2:0]  req0_op, req1_op;
  logic [31:0] alu_data1, alu_data2;
  logic [2:0]  alu_op;
  logic [31:0] alu_result;
  logic        alu_zero, alu_branch;
  logic        rsp_valid, rsp_ready, rsp_id;
  logic [31:0] rsp_result;
  logic        rsp_zero, rsp_branch, rsp_err;

  int checks;
  int failures;

  alu_arbiter #(.WIDTH(32), .OPW(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req1_valid (req1_valid),
    .req0_ready (req0_ready),
    .req1_ready (req1_ready),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req0_op    (req0_op),
    .req1_op    (req1_op),
    .alu_data1  (alu_data1),
    .alu_data2  (alu_data2),
    .alu_op     (alu_op),
    .alu_result (alu_result),
    .alu_zero   (alu_zero),
    .alu_branch (alu_branch),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .rsp_zero   (rsp_zero),
    .rsp_branch (rsp_branch),
    .rsp_err    (rsp_err)
  );

  // clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // behavioural ALU
  always_comb begin
    alu_result = 32'h0;
    alu_zero   = 1'b0;
    alu_branch = (alu_data1 == alu_data2);
    case (alu_op)
      3'b010: alu_result = alu_data1 + alu_data2;
      3'b110: alu_result = alu_data1 - alu_data2;
      3'b000: alu_result = alu_data1 & alu_data2;
      3'b001: alu_result = alu_data1 | alu_data2;
      3'b111: alu_result = ($signed(alu_data1) < $signed(alu_data2)) ? 32'd1 : 32'd0;
      3'b101: begin alu_result = 32'h0000_0abc; alu_branch = (alu_data1 == alu_data2); end
      3'b011: begin alu_result = 32'h0000_0abc; alu_branch = (alu_data1 != alu_data2); end
      default: begin alu_result = 32'hdead_beef; alu_branch = 1'b1; end
    endcase
    alu_zero = (alu_result == 32'h0);
    if (alu_op == 3'b101 || alu_op == 3'b011 || alu_op == 3'b100) alu_zero = 1'b1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_rsp(input string tag, input logic id, input logic [31:0] res,
                           input logic z, input logic br, input logic er);
    chk({tag, ".valid"},  32'(rsp_valid),  32'd1);
    chk({tag, ".id"},     32'(rsp_id),     32'(id));
    chk({tag, ".result"}, rsp_result,      res);
    chk({tag, ".zero"},   32'(rsp_zero),   32'(z));
    chk({tag, ".branch"}, 32'(rsp_branch), 32'(br));
    chk({tag, ".err"},    32'(rsp_err),    32'(er));
  endtask

  task automatic drive0(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
    req0_valid = 1'b1; req0_a = a; req0_b = b; req0_op = op;
  endtask

  task automatic drive1(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op);
    req1_valid = 1'b1; req1_a = a; req1_b = b; req1_op = op;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, ".req0_ready"}, 32'(req0_ready), 32'd0);
    chk({tag, ".req1_ready"}, 32'(req1_ready), 32'd0);
    chk({tag, ".alu_data1"},  alu_data1,       32'd0);
    chk({tag, ".alu_data2"},  alu_data2,       32'd0);
    chk({tag, ".alu_op"},     32'(alu_op),     32'd0);
    chk({tag, ".rsp_valid"},  32'(rsp_valid),  32'd0);
    chk({tag, ".rsp_id"},     32'(rsp_id),     32'd0);
    chk({tag, ".rsp_result"}, rsp_result,      32'd0);
    chk({tag, ".rsp_flags"},  32'({rsp_zero, rsp_branch, rsp_err}), 32'd0);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    req0_a = '0; req0_b = '0; req0_op = '0;
    req1_a = '0; req1_b = '0; req1_op = '0;
    rsp_ready = 1'b1;

    // reset state
    @(negedge clk); #1;
    check_all_zero("reset");
    @(negedge clk); rst = 1'b0;

    // req0 ADD 5,7: ready in N, response in N+2
    @(negedge clk); drive0(32'd5, 32'd7, 3'b010); #1;
    chk("add.req0_ready", 32'(req0_ready), 32'd1);
    chk("add.req1_ready", 32'(req1_ready), 32'd0);
    @(negedge clk); req0_valid = 1'b0; #1;
    chk("add.issue_no_rsp", 32'(rsp_valid), 32'd0);
    chk("add.alu_data1", alu_data1, 32'd5);
    chk("add.alu_data2", alu_data2, 32'd7);
    chk("add.alu_op", 32'(alu_op), 32'b010);
    @(negedge clk); #1;
    check_rsp("add", 1'b0, 32'd12, 1'b0, 1'b0, 1'b0);
    chk("add.alu_hold", alu_data1, 32'd5);

    // req1 BEQ 3,3 then BNE 3,3
    @(negedge clk); drive1(32'd3, 32'd3, 3'b101); #1;
    chk("beq.req1_ready", 32'(req1_ready), 32'd1);
    @(negedge clk); req1_valid = 1'b0;
    @(negedge clk); #1;
    check_rsp("beq", 1'b1, 32'd0, 1'b0, 1'b1, 1'b0);
    @(negedge clk); drive1(32'd3, 32'd3, 3'b011); #1;
    chk("bne.req1_ready", 32'(req1_ready), 32'd1);
    @(negedge clk); req1_valid = 1'b0;
    @(negedge clk); #1;
    check_rsp("bne", 1'b1, 32'd0, 1'b0, 1'b0, 1'b0);

    // tie after req1 won last: req0 SUB 9,9 first, then req1 OR
    @(negedge clk); drive0(32'd9, 32'd9, 3'b110); drive1(32'hf0, 32'h0f, 3'b001); #1;
    chk("tie1.req0_ready", 32'(req0_ready), 32'd1);
    chk("tie1.req1_ready", 32'(req1_ready), 32'd0);
    @(negedge clk); drive0(32'hff, 32'h0f, 3'b000); #1;
    chk("tie1.issue_ready", 32'({req1_ready, req0_ready}), 32'd0);
    @(negedge clk); #1;
    check_rsp("sub", 1'b0, 32'd0, 1'b1, 1'b0, 1'b0);
    // second tie, req0 won last: req1 goes first
    @(negedge clk); #1;
    chk("tie2.req1_ready", 32'(req1_ready), 32'd1);
    chk("tie2.req0_ready", 32'(req0_ready), 32'd0);
    @(negedge clk); req1_valid = 1'b0;
    @(negedge clk); #1;
    check_rsp("or", 1'b1, 32'hff, 1'b0, 1'b0, 1'b0);
    @(negedge clk); #1;
    chk("and.req0_ready", 32'(req0_ready), 32'd1);
    @(negedge clk); req0_valid = 1'b0;
    @(negedge clk); #1;
    check_rsp("and", 1'b0, 32'h0f, 1'b0, 1'b0, 1'b0);

    // backpressure: rsp_ready low for 5 cycles with req1 waiting
    @(negedge clk); drive0(32'd2, 32'd5, 3'b111); rsp_ready = 1'b0; #1;
    chk("slt.req0_ready", 32'(req0_ready), 32'd1);
    @(negedge clk); req0_valid = 1'b0;
    @(negedge clk); drive1(32'd1, 32'd2, 3'b010); #1;
    check_rsp("slt", 1'b0, 32'd1, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk); #1;
      chk("stall.rsp_valid", 32'(rsp_valid), 32'd1);
      chk("stall.rsp_result", rsp_result, 32'd1);
      chk("stall.rsp_id", 32'(rsp_id), 32'd0);
      chk("stall.req1_ready", 32'(req1_ready), 32'd0);
    end
    @(negedge clk); rsp_ready = 1'b1; #1;
    chk("handshake_cycle.req1_ready", 32'(req1_ready), 32'd0);
    @(negedge clk); #1;
    chk("after_hs.req1_ready", 32'(req1_ready), 32'd1);
    @(negedge clk); req1_valid = 1'b0;
    @(negedge clk); #1;
    check_rsp("add2", 1'b1, 32'd3, 1'b0, 1'b0, 1'b0);

    // illegal opcode 100
    @(negedge clk); drive1(32'd1, 32'd1, 3'b100); #1;
    chk("ill.req1_ready", 32'(req1_ready), 32'd1);
    @(negedge clk); req1_valid = 1'b0;
    @(negedge clk); #1;
    check_rsp("ill", 1'b1, 32'd0, 1'b0, 1'b0, 1'b1);

    // reset pulsed during ISSUE
    @(negedge clk); drive0(32'd1, 32'd1, 3'b010); #1;
    chk("rstop.req0_ready", 32'(req0_ready), 32'd1);
    @(negedge clk); req0_valid = 1'b0; rst = 1'b1; #1;
    check_all_zero("rst_issue");
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); #1;
      chk("rst_issue.no_rsp", 32'(rsp_valid), 32'd0);
    end
    // history restored: req0 wins the first tie again
    @(negedge clk); drive0(32'd4, 32'd4, 3'b010); drive1(32'd6, 32'd6, 3'b010); #1;
    chk("rst_tie.req0_ready", 32'(req0_ready), 32'd1);
    chk("rst_tie.req1_ready", 32'(req1_ready), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Two-port round-robin arbiter and sequencer that shares one combinational 32-bit ALU between two requesters, e.g. the main datapath and a branch-compare or address-generation unit. It accepts one operation at a time over a valid/ready handshake and drives the ALU operand and opcode ports from registered values. It captures the ALU outputs and returns them with the winning requester's id over a valid/ready response channel. It sits directly in front of the ALU, and all ALU traffic passes through it.

## Interface
- WIDTH, 32, operand/result width
- OPW, 3, ALU opcode width
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- req0_valid, req1_valid  in  1  request present
- req0_ready, req1_ready  out  1  request accepted this cycle
- req0_a, req0_b, req1_a, req1_b  in  WIDTH  operands
- req0_op, req1_op  in  OPW  opcode: 010 ADD, 110 SUB, 000 AND, 001 OR, 111 SLT, 011 BNE, 101 BEQ
- alu_data1, alu_data2  out  WIDTH  to the ALU
- alu_op  out  OPW  to the ALU
- alu_result  in  WIDTH  from the ALU
- alu_zero, alu_branch  in  1  from the ALU
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts
- rsp_id  out  1  requester id, 0 or 1
- rsp_result  out  WIDTH  result
- rsp_zero, rsp_branch, rsp_err  out  1  flags

## Operation
- FSM states: IDLE, ISSUE, RESP.
- IDLE
  - If either valid is high, grant one requester and assert its reqN_ready combinationally in this cycle.
  - Capture the granted a, b, op and id into the issue registers, then go to ISSUE.
  - If neither valid is high, stay in IDLE.
- Round robin
  - When both valid are high, grant the requester that is not last_grant.
  - When only one valid is high, grant that requester regardless of last_grant.
  - last_grant updates at the response handshake.
- ISSUE: alu_data1, alu_data2 and alu_op come straight from the issue registers. At the end of the cycle, latch the response fields and go to RESP.
- Response masking by opcode:
  - Arithmetic/logic ops: rsp_result = alu_result, rsp_zero = alu_zero, rsp_branch = 0.
  - BNE/BEQ: rsp_branch = alu_branch, rsp_result = 0, rsp_zero = 0.
  - Opcode 100: the ALU is not trusted. rsp_err = 1 and all other flags and the result are 0. The response is still returned.
- RESP: rsp_valid = 1. All rsp_* fields stay stable until rsp_ready is high, then go to IDLE. reqN_ready stays 0 while in RESP.
- ALU port drive: alu_* outputs always come from the issue registers and hold their value outside ISSUE; they do not toggle.
- Requester rule: a requester holds valid and its data stable until it sees ready. Dropping valid before ready is legal; no grant occurs in that case.

## Timing
- Reset values:
  - FSM state is IDLE.
  - All outputs are 0, including req*_ready, rsp_*, alu_data1, alu_data2 and alu_op.
  - last_grant = 1, so req0 wins the first tie.
- Latency: request handshake in cycle N gives rsp_valid in cycle N+2 at the earliest.
- Throughput: at most one operation per 3 cycles with rsp_ready held high.
- A response handshake and a new request in the same cycle: the new request is not accepted until the following cycle, in IDLE.
- Reset asserted in ISSUE or RESP: the in-flight operation is discarded with no response, and all outputs return to reset values immediately.
- rsp_ready held low: the FSM stays in RESP indefinitely and no request is accepted.

## Structure
- Shared package holds:
  - opcode localparams: OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_BNE, OP_BEQ, OP_ILLEGAL = 100;
  - the FSM state encoding (IDLE, ISSUE, RESP);
  - an is_branch(op) helper.
- One sub-module: rr_arb2, a 2-input round-robin grant with a registered last_grant and an update strobe.
- The ALU itself is instantiated outside this block, beside it.

## Test plan
- Reset then req0 ADD 5, 7: req0_ready in cycle N, and rsp_valid in N+2 with id 0, result 12, zero 0, branch 0, err 0.
- Both valid in the same cycle, req0 SUB 9, 9 and req1 OR 0xF0, 0x0F:
  - req0 is served first with result 0, zero 1;
  - req1 is served next with result 0xFF;
  - a second simultaneous pair is served req1 first.
- req1 BEQ 3, 3 gives branch 1, result 0, zero 0; BNE 3, 3 gives branch 0.
- rsp_ready low for 5 cycles with req1 valid:
  - rsp fields stay stable and req1_ready stays 0;
  - after the response handshake, req1 is accepted in the next cycle.
- Opcode 100: a response with err 1, result 0, zero 0 and branch 0.
- rst pulsed during ISSUE: no rsp_valid ever appears for that operation, and all outputs are 0 after reset.
